// File: rtl/scan_mux_n_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// scan_mux_n_if
//
// Bundle between a bank of sampled sources plus a select controller (master)
// and the scanning multiplexer (slave).
//
//   din        master->slave  packed channels, channel k at [k*WIDTH +: WIDTH]
//   mode       master->slave  0 = manual select, 1 = auto-scan
//   sel_in     master->slave  channel index offered for loading
//   sel_load   master->slave  load sel_in into the select register
//   hold       master->slave  freeze select, dwell counter and output
//   dout       slave->master  registered selected channel data
//   dout_valid slave->master  dout belongs to sel_cur
//   sel_cur    slave->master  current select register
//   wrap       slave->master  one-cycle pulse on scan step CH-1 -> 0
//   sel_err    slave->master  one-cycle pulse on a load with sel_in >= CH
// -----------------------------------------------------------------------------
interface scan_mux_n_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = 2
);

    logic [CH*WIDTH-1:0] din;
    logic                mode;
    logic [SELW-1:0]     sel_in;
    logic                sel_load;
    logic                hold;

    logic [WIDTH-1:0]    dout;
    logic                dout_valid;
    logic [SELW-1:0]     sel_cur;
    logic                wrap;
    logic                sel_err;

    modport master (
        output din, mode, sel_in, sel_load, hold,
        input  dout, dout_valid, sel_cur, wrap, sel_err
    );

    modport slave (
        input  din, mode, sel_in, sel_load, hold,
        output dout, dout_valid, sel_cur, wrap, sel_err
    );

endinterface : scan_mux_n_if

// File: rtl/scan_mux_n.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// scan_mux_n
//
// CH-channel, WIDTH-bit registered multiplexer with an internal select
// register. In manual mode the select only changes by an explicit load; in
// auto-scan mode it steps through the channels, dwelling DWELL cycles on each.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous, active-low reset
//   bus    scan_mux_n_if.slave: data/control inputs, data/status outputs
//
// Per-edge priority: reset > hold > sel_load > scan advance.
// All outputs are registered; nothing on the interface is combinational.
// -----------------------------------------------------------------------------
module scan_mux_n #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    scan_mux_n_if.slave  bus
);

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Dwell counter only needs to reach DWELL-1; keep at least one bit so the
    // DWELL=1 build still has a legal (constant-zero) counter.
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DCW-1:0]  LAST_DWELL = DCW'(DWELL - 1);
    localparam logic [SELW-1:0] LAST_CH    = SELW'(CH - 1);
    // One extra bit so CH = 2**SELW is representable in the range compare.
    localparam logic [SELW:0]   CH_LIMIT   = (SELW + 1)'(CH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SELW-1:0]  sel_q;
    logic [DCW-1:0]   dwell_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             wrap_q;
    logic             err_q;

    // ------------------------------------------------------------------
    // Channel unpacking
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ch_data [CH];

    for (genvar k = 0; k < CH; k++) begin : g_unpack
        assign ch_data[k] = bus.din[k*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Next-state decode (used only on non-hold edges)
    // ------------------------------------------------------------------
    logic             sel_in_ok;
    logic             load_ok;
    logic             last_dwell;
    logic             last_ch;
    logic [SELW-1:0]  sel_nxt;
    logic [DCW-1:0]   dwell_nxt;
    logic             wrap_nxt;
    logic             err_nxt;
    logic [WIDTH-1:0] dout_nxt;

    assign sel_in_ok  = ({1'b0, bus.sel_in} < CH_LIMIT);
    assign load_ok    = bus.sel_load && sel_in_ok;
    assign last_dwell = (dwell_q == LAST_DWELL);
    assign last_ch    = (sel_q == LAST_CH);

    // Data path always samples the channel selected before this edge, so a
    // new select shows up on dout one cycle after sel_cur moves.
    assign dout_nxt = ch_data[sel_q];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the branches can leave a value unassigned and infer a latch.
        sel_nxt   = sel_q;
        dwell_nxt = dwell_q;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;

        if (load_ok) begin
            sel_nxt   = bus.sel_in;
            dwell_nxt = '0;
        end else begin
            // An out-of-range load is flagged and otherwise behaves as if no
            // load had been requested, so the scan carries on undisturbed.
            err_nxt = bus.sel_load;

            if (mode_e'(bus.mode) == MODE_SCAN) begin
                if (last_dwell) begin
                    dwell_nxt = '0;
                    // Explicit compare-and-clear keeps non-power-of-two CH
                    // from ever reaching an unused select code.
                    if (last_ch) begin
                        sel_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        sel_nxt = sel_q + SELW'(1);
                    end
                end else begin
                    dwell_nxt = dwell_q + DCW'(1);
                end
            end else begin
                // Manual mode parks the dwell counter so that entering scan
                // mode always starts a full dwell on the current channel.
                dwell_nxt = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q   <= '0;
            dwell_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.hold) begin
            // Frozen: select, dwell, data and valid keep their values; the
            // pulses are cleared and any load request is silently dropped.
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sel_q   <= sel_nxt;
            dwell_q <= dwell_nxt;
            dout_q  <= dout_nxt;
            // dout lags sel_cur by one edge, so it is stale exactly when the
            // select moves on this edge.
            valid_q <= (sel_nxt == sel_q);
            wrap_q  <= wrap_nxt;
            err_q   <= err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.sel_cur    = sel_q;
    assign bus.wrap       = wrap_q;
    assign bus.sel_err    = err_q;

endmodule : scan_mux_n

// File: tb/tb_scan_mux_n.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_scan_mux_n
//
// Three builds share one clock, one reset and one set of control inputs:
//   A: CH=4, DWELL=10   (main build)
//   B: CH=3, DWELL=10   (non-power-of-two channel count, invalid select code)
//   C: CH=4, DWELL=1    (advance every cycle)
// Every cycle a reference model predicts each build's outputs; predictions are
// queued when the inputs are driven and popped after the edge. Directed
// constant checks at the key points of each scenario sit on top of that.
// -----------------------------------------------------------------------------
module tb_scan_mux_n;

    localparam int WIDTH  = 8;
    localparam int CH_A   = 4;
    localparam int SELW_A = 2;
    localparam int DWL_A  = 10;
    localparam int CH_B   = 3;
    localparam int SELW_B = 2;
    localparam int DWL_B  = 10;
    localparam int CH_C   = 4;
    localparam int SELW_C = 2;
    localparam int DWL_C  = 1;
    localparam int NDUT   = 3;

    if (SELW_A != $clog2(CH_A)) begin : g_bad_selw_a
        initial $fatal(1, "FAIL selw_a: SELW does not match CH");
    end
    if (SELW_B != $clog2(CH_B)) begin : g_bad_selw_b
        initial $fatal(1, "FAIL selw_b: SELW does not match CH");
    end
    if (SELW_C != $clog2(CH_C)) begin : g_bad_selw_c
        initial $fatal(1, "FAIL selw_c: SELW does not match CH");
    end

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel_in;
    logic       sel_load;
    logic       hold;

    always #5 clk = ~clk;

    scan_mux_n_if #(.WIDTH(WIDTH), .CH(CH_A), .SELW(SELW_A)) if_a ();
    scan_mux_n_if #(.WIDTH(WIDTH), .CH(CH_B), .SELW(SELW_B)) if_b ();
    scan_mux_n_if #(.WIDTH(WIDTH), .CH(CH_C), .SELW(SELW_C)) if_c ();

    assign if_a.din = 32'hDDCC_BBAA;
    assign if_b.din = 24'hCC_BBAA;
    assign if_c.din = 32'hDDCC_BBAA;

    assign if_a.mode = mode;  assign if_a.sel_in = sel_in;
    assign if_a.sel_load = sel_load;  assign if_a.hold = hold;
    assign if_b.mode = mode;  assign if_b.sel_in = sel_in;
    assign if_b.sel_load = sel_load;  assign if_b.hold = hold;
    assign if_c.mode = mode;  assign if_c.sel_in = sel_in;
    assign if_c.sel_load = sel_load;  assign if_c.hold = hold;

    scan_mux_n #(.WIDTH(WIDTH), .CH(CH_A), .SELW(SELW_A), .DWELL(DWL_A)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    scan_mux_n #(.WIDTH(WIDTH), .CH(CH_B), .SELW(SELW_B), .DWELL(DWL_B)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );
    scan_mux_n #(.WIDTH(WIDTH), .CH(CH_C), .SELW(SELW_C), .DWELL(DWL_C)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c)
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int sel;
        int cnt;
        int dout;
        int valid;
        int wrap;
        int err;
    } mstate_t;

    typedef struct {
        int      dut;
        mstate_t e;
        string   tag;
    } sb_entry_t;

    mstate_t   ms [NDUT];
    sb_entry_t sb_q [$];
    int        checks = 0;
    int        errors = 0;

    function automatic int ch_of(input int d);
        case (d)
            1:       return CH_B;
            2:       return CH_C;
            default: return CH_A;
        endcase
    endfunction

    function automatic int dwell_of(input int d);
        case (d)
            1:       return DWL_B;
            2:       return DWL_C;
            default: return DWL_A;
        endcase
    endfunction

    function automatic string name_of(input int d);
        case (d)
            1:       return "B";
            2:       return "C";
            default: return "A";
        endcase
    endfunction

    // Channel k of every build carries AA + k*0x11.
    function automatic int chan_val(input int k);
        return 8'hAA + 8'h11 * k;
    endfunction

    function automatic mstate_t ref_next(input mstate_t s, input int d);
        mstate_t n;
        int      ch;
        int      dw;
        ch = ch_of(d);
        dw = dwell_of(d);
        n  = s;
        n.wrap = 0;
        n.err  = 0;
        if (!rst_n) begin
            n = '{sel: 0, cnt: 0, dout: 0, valid: 0, wrap: 0, err: 0};
        end else if (!hold) begin
            n.dout = chan_val(s.sel);
            if (sel_load && int'(sel_in) < ch) begin
                n.sel = int'(sel_in);
                n.cnt = 0;
            end else begin
                n.err = sel_load ? 1 : 0;
                if (!mode) begin
                    n.cnt = 0;
                end else if (s.cnt + 1 >= dw) begin
                    n.cnt  = 0;
                    n.sel  = (s.sel + 1) % ch;
                    n.wrap = (n.sel == 0) ? 1 : 0;
                end else begin
                    n.cnt = s.cnt + 1;
                end
            end
            n.valid = (n.sel == s.sel) ? 1 : 0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_entry(input sb_entry_t it);
        logic [31:0] o_sel, o_dout, o_valid, o_wrap, o_err;
        string       t;
        case (it.dut)
            1: begin
                o_sel = 32'(if_b.sel_cur);   o_dout = 32'(if_b.dout);
                o_valid = 32'(if_b.dout_valid); o_wrap = 32'(if_b.wrap);
                o_err = 32'(if_b.sel_err);
            end
            2: begin
                o_sel = 32'(if_c.sel_cur);   o_dout = 32'(if_c.dout);
                o_valid = 32'(if_c.dout_valid); o_wrap = 32'(if_c.wrap);
                o_err = 32'(if_c.sel_err);
            end
            default: begin
                o_sel = 32'(if_a.sel_cur);   o_dout = 32'(if_a.dout);
                o_valid = 32'(if_a.dout_valid); o_wrap = 32'(if_a.wrap);
                o_err = 32'(if_a.sel_err);
            end
        endcase
        t = $sformatf("%s/%s", it.tag, name_of(it.dut));
        check({t, "/sel_cur"},    o_sel,   32'(it.e.sel));
        check({t, "/dout"},       o_dout,  32'(it.e.dout));
        check({t, "/dout_valid"}, o_valid, 32'(it.e.valid));
        check({t, "/wrap"},       o_wrap,  32'(it.e.wrap));
        check({t, "/sel_err"},    o_err,   32'(it.e.err));
    endtask

    // One clock edge: predict with the inputs now on the pins, then compare
    // one time unit after the edge.
    task automatic tick(input string tag);
        sb_entry_t it;
        for (int d = 0; d < NDUT; d++) begin
            ms[d] = ref_next(ms[d], d);
            it.dut = d;
            it.e   = ms[d];
            it.tag = tag;
            sb_q.push_back(it);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            compare_entry(it);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int wraps;
        for (int d = 0; d < NDUT; d++) ms[d] = '{sel: 0, cnt: 0, dout: 0, valid: 0, wrap: 0, err: 0};
        rst_n = 1'b0; mode = 1'b0; sel_in = 2'd0; sel_load = 1'b0; hold = 1'b0;

        // Reset held for three cycles.
        repeat (3) tick("reset");
        check("reset/sel_cur",    32'(if_a.sel_cur), 0);
        check("reset/dout",       32'(if_a.dout), 0);
        check("reset/dout_valid", 32'(if_a.dout_valid), 0);

        // Manual load of channel 2.
        rst_n = 1'b1;
        tick("release");
        sel_load = 1'b1; sel_in = 2'd2;
        tick("load2");
        check("load2/sel_cur", 32'(if_a.sel_cur), 2);
        check("load2/valid",   32'(if_a.dout_valid), 0);
        sel_load = 1'b0;
        tick("load2_data");
        check("load2_data/dout",  32'(if_a.dout), 32'hCC);
        check("load2_data/valid", 32'(if_a.dout_valid), 1);

        // Back to channel 0, then auto-scan a full revolution.
        sel_load = 1'b1; sel_in = 2'd0;
        tick("load0");
        sel_load = 1'b0;
        tick("idle0");
        mode  = 1'b1;
        wraps = 0;
        for (int k = 1; k <= 40; k++) begin
            tick("scan");
            wraps += int'(if_a.wrap);
            if (k % 10 == 0) check("scan/step_sel", 32'(if_a.sel_cur), 32'((k / 10) % 4));
            if (k == 9)  check("scan/pre_step_sel", 32'(if_a.sel_cur), 0);
            if (k == 10) check("scan/step_valid", 32'(if_a.dout_valid), 0);
            if (k == 11) check("scan/bb_dout", 32'(if_a.dout), 32'hBB);
            if (k == 21) check("scan/cc_dout", 32'(if_a.dout), 32'hCC);
            if (k == 31) check("scan/dd_dout", 32'(if_a.dout), 32'hDD);
            if (k == 40) check("scan/wrap", 32'(if_a.wrap), 1);
        end
        check("scan/wrap_count", 32'(wraps), 1);

        // Hold for five cycles at dwell count 4 on channel 1; a load offered
        // during the hold is ignored and never flagged.
        repeat (14) tick("to_ch1");
        hold = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) begin sel_load = 1'b1; sel_in = 2'd3; end
            tick("hold");
            sel_load = 1'b0;
            check("hold/sel_cur", 32'(if_a.sel_cur), 1);
            check("hold/dout",    32'(if_a.dout), 32'hBB);
            check("hold/err_b",   32'(if_b.sel_err), 0);
        end
        hold = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick("after_hold");
            check("after_hold/sel_cur", 32'(if_a.sel_cur), (k == 6) ? 2 : 1);
        end

        // Load of channel 3 at dwell count 7 during scan.
        repeat (7) tick("dwell7");
        sel_load = 1'b1; sel_in = 2'd3;
        tick("scan_load3");
        check("scan_load3/sel_cur_a", 32'(if_a.sel_cur), 3);
        check("scan_load3/err_a",     32'(if_a.sel_err), 0);
        check("scan_load3/err_b",     32'(if_b.sel_err), 1);
        sel_load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick("scan_from3");
            check("scan_from3/sel_cur", 32'(if_a.sel_cur), (k == 10) ? 0 : 3);
            check("scan_from3/wrap",    32'(if_a.wrap),    (k == 10) ? 1 : 0);
        end

        // Invalid load on the 3-channel build in manual mode, then its scan
        // wraps 2 -> 0.
        mode = 1'b0;
        sel_load = 1'b1; sel_in = 2'd2;
        tick("man_load2");
        sel_in = 2'd3;
        tick("bad_load3");
        check("bad_load3/err_b",  32'(if_b.sel_err), 1);
        check("bad_load3/sel_b",  32'(if_b.sel_cur), 2);
        sel_load = 1'b0;
        tick("err_clear");
        check("err_clear/err_b", 32'(if_b.sel_err), 0);
        mode = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick("b_wrap");
            check("b_wrap/sel_b",  32'(if_b.sel_cur), (k == 10) ? 0 : 2);
            check("b_wrap/wrap_b", 32'(if_b.wrap),    (k == 10) ? 1 : 0);
        end

        // Reset mid-scan, then restart scanning from channel 0.
        repeat (5) tick("pre_reset");
        rst_n = 1'b0;
        tick("mid_reset");
        check("mid_reset/sel_a", 32'(if_a.sel_cur), 0);
        check("mid_reset/sel_c", 32'(if_c.sel_cur), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick("restart");
            check("restart/sel_a",   32'(if_a.sel_cur), (k == 10) ? 1 : 0);
            check("restart/sel_c",   32'(if_c.sel_cur), 32'(k % 4));
            check("restart/valid_c", 32'(if_c.dout_valid), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_scan_mux_n

// File: doc/scan_mux_n.md
# scan_mux_n

Parametrised N-channel, W-bit registered multiplexer with manual and auto-scan select modes. It is the successor to the combinational 4-to-1 mux and moves the select counter into the block. Scan mode steps through the channels, holding each one for a programmable dwell time. It sits between a bank of sampled data sources and a single downstream consumer, for example a display or a serial logger.

## Interface
Parameters:
- WIDTH, 8, bit width of each channel.
- CH, 4, number of channels; 2..256.
- SELW, 2, select width. Must equal ceil(log2(CH)); the bench checks this with an elaboration assertion.
- DWELL, 10, clock cycles spent on each channel in scan mode; must be ≥1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- din, input, CH*WIDTH: packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- mode, input, 1: 0 = manual, 1 = auto-scan.
- sel_in, input, SELW: channel index to load.
- sel_load, input, 1: load sel_in into the select register this cycle.
- hold, input, 1: freeze select, dwell counter and dout.
- dout, output, WIDTH: registered selected channel.
- dout_valid, output, 1: dout corresponds to sel_cur.
- sel_cur, output, SELW: current select register.
- wrap, output, 1: one-cycle pulse when scan steps CH-1 → 0.
- sel_err, output, 1: one-cycle pulse when sel_load carries sel_in ≥ CH.

## Operation
- Reset (rst_n=0 at a clock edge) sets the following, regardless of other inputs:
  - sel_cur=0, dout=0, dout_valid=0, wrap=0, sel_err=0.
  - Dwell counter = 0.
- Per-edge priority is hold > sel_load > scan advance.
- hold=1:
  - sel_cur, dwell counter, dout and dout_valid keep their values.
  - wrap=0 and sel_err=0.
  - sel_load is ignored and is not flagged as an error.
- sel_load=1, hold=0:
  - If sel_in < CH: sel_cur←sel_in and the dwell counter←0, in either mode.
  - If sel_in ≥ CH: sel_cur is unchanged, sel_err=1 for one cycle, and the dwell counter behaves as if sel_load=0.
- Manual mode (mode=0): sel_cur changes only via sel_load. The dwell counter is held at 0.
- Scan mode (mode=1, no load, no hold):
  - The dwell counter increments each cycle.
  - When it reaches DWELL-1, the counter←0 and sel_cur←(sel_cur+1) mod CH.
  - wrap=1 on the edge where sel_cur goes CH-1 → 0.
- Mode switch:
  - scan→manual: sel_cur keeps its value and the dwell counter clears.
  - manual→scan: dwell starts from 0 on the current channel, so the first step comes DWELL cycles later.
- Data path: each non-hold edge samples dout←din[sel_cur*WIDTH +: WIDTH] using the pre-edge sel_cur.
- dout_valid:
  - Goes to 0 on any edge where sel_cur changes.
  - Otherwise goes to 1 on any non-hold edge.
  - Consequently it is low for exactly one cycle after every select change and for the first cycle after reset release.
- Non-power-of-two CH: the wrap arithmetic is explicit compare-and-clear, not bit overflow, so sel_cur never exceeds CH-1.

## Timing
- din → dout latency: 1 cycle.
- sel_load → sel_cur: 1 cycle. The new channel appears on dout 2 cycles after the sel_load edge, with dout_valid=1 on that same cycle.
- Scan period: sel_cur changes every DWELL cycles; a full cycle through all channels takes CH*DWELL cycles.
- DWELL=1: sel_cur advances every cycle and dout_valid stays 0 while scanning.
- wrap and sel_err are registered single-cycle pulses, aligned with the sel_cur update edge.
- Reset asserted mid-scan takes effect at the next edge: all outputs go to their reset values and the next scan starts from channel 0 with a full dwell.
- Everything is synchronous; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use CH=4, WIDTH=8, DWELL=10, with din channels = {8'hDD, 8'hCC, 8'hBB, 8'hAA} (channel 0 = AA).
- Reset and manual load:
  - Hold rst_n low for 3 cycles: all outputs are 0.
  - mode=0, sel_load with sel_in=2: sel_cur=2 after 1 edge; dout=8'hCC and dout_valid=1 after 2 edges.
- Auto-scan: mode=1 from sel_cur=0.
  - sel_cur steps 0,1,2,3,0 at cycles 10,20,30,40.
  - wrap pulses once, at cycle 40.
  - dout follows AA, BB, CC, DD with 1-cycle lag.
- Hold mid-scan: assert hold for 5 cycles at dwell count 4 on channel 1.
  - sel_cur and dout are frozen.
  - After release, the step to channel 2 occurs 6 cycles later.
- Invalid load (CH=3 build, SELW=2): sel_load with sel_in=3 → sel_err=1 for one cycle, sel_cur unchanged.
  - Scan from 2 goes to 0 with wrap=1.
- Load during scan: mode=1, sel_load with sel_in=3 at dwell count 7 → sel_cur=3, the dwell restarts, and the next step to 0 (with wrap) comes 10 cycles later.
- Reset mid-scan, then DWELL=1 build:
  - Reset mid-scan returns sel_cur to 0 on the next edge.
  - With DWELL=1, sel_cur increments every cycle and dout_valid stays 0.
